sdp_rdma_rd_arb: RTL and testbench

Four-way read-request arbiter and response router in front of the SDP RDMA DMA interface. It shares one `dma_rd_req`/`dma_rd_rsp` port between the MRDMA, BRDMA, NRDMA and ERDMA requesters (ids 0..3) using round-robin arbitration. Each grant is gated by per-requester latency-FIFO credits and by free space in an in-order tag FIFO. Response beats are steered back to the requester that issued the matching request.

---
 rtl/sdp_rdma_rd_arb.sv | 224 ++++++++++++++++++++++
 tb/tb_sdp_rdma_rd_arb.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_rdma_rd_arb.sv
// Four-way round-robin read-request arbiter with in-order response steering.
// Latency: request grant is combinational (0 cycles); responses pass straight through.
// Backpressure: grants are gated by credits, tag space and dma_rd_req_rdy; beats stall on the owner's rsp_rdy.
// Optional build macro: SDP_RDMA_ARB_PERF_EN adds saturating per-requester grant/stall counters.
module sdp_rdma_rd_arb #(
  parameter int LAT_DEPTH = 64,
  parameter int TAG_DEPTH = 8
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic [3:0]       req_vld,
  output logic [3:0]       req_rdy,
  input  logic [3:0][78:0] req_pd,
  input  logic [3:0]       req_ram_type,
  input  logic [3:0]       req_cdt_pop,
  output logic             dma_rd_req_vld,
  input  logic             dma_rd_req_rdy,
  output logic [78:0]      dma_rd_req_pd,
  output logic             dma_rd_req_ram_type,
  input  logic             dma_rd_rsp_vld,
  output logic             dma_rd_rsp_rdy,
  input  logic [256:0]     dma_rd_rsp_pd,
  output logic             dma_rd_rsp_ram_type,
  output logic [3:0]       rsp_vld,
  input  logic [3:0]       rsp_rdy,
  output logic [256:0]     rsp_pd,
  output logic             arb_err
`ifdef SDP_RDMA_ARB_PERF_EN
  ,
  output logic [3:0][31:0] perf_grant_cnt,
  output logic [3:0][31:0] perf_stall_cnt
`endif
);

  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam int TAG_CW = TAG_AW + 1;

  typedef enum logic [0:0] {ST_IDLE, ST_HOLD} state_t;

  // Tag entry keeps size (beats-1) so the last-beat test is a direct compare.
  typedef struct packed {
    logic [1:0]  id;
    logic        ram_type;
    logic [14:0] size;
  } tag_t;

  state_t            state_q;
  logic [1:0]        hold_id_q;
  logic [1:0]        rr_ptr_q;
  logic [3:0][7:0]   out_q;
  tag_t              tag_mem_q [TAG_DEPTH];
  logic [TAG_AW-1:0] wr_ptr_q;
  logic [TAG_AW-1:0] rd_ptr_q;
  logic [TAG_CW-1:0] tag_cnt_q;
  logic [14:0]       beat_cnt_q;
  logic              err_q;

  logic [3:0][15:0]  beats;
  logic [3:0]        too_big;
  logic [3:0][8:0]   need;
  logic [3:0]        eligible;
  logic [3:0]        pop_ok;
  logic              tag_full;
  logic              pick_vld;
  logic [1:0]        pick_id;
  logic              gnt_vld;
  logic [1:0]        gnt_id;
  logic              accept;
  tag_t              new_tag;
  tag_t              head;
  logic              head_vld;
  logic              rsp_beat;
  logic              tag_pop;

  // Per-requester beat count and credit/tag eligibility (pre-update values)
  always_comb begin
    tag_full = (tag_cnt_q == TAG_CW'(TAG_DEPTH));
    for (int i = 0; i < 4; i++) begin
      beats[i]    = {1'b0, req_pd[i][78:64]} + 16'd1;
      too_big[i]  = (beats[i] > 16'(LAT_DEPTH));
      need[i]     = {1'b0, out_q[i]} + beats[i][8:0];
      eligible[i] = req_vld[i] & ~too_big[i] & (need[i] <= 9'(LAT_DEPTH)) & ~tag_full;
      pop_ok[i]   = req_cdt_pop[i] & (out_q[i] != 8'd0);
    end
  end

  // Round-robin pick: lowest offset from rr_ptr wins
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (eligible[rr_ptr_q + 2'(k)]) begin
        pick_vld = 1'b1;
        pick_id  = rr_ptr_q + 2'(k);
      end
    end
  end

  // Request mux: a held requester is driven without re-arbitration
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = rr_ptr_q;
    if (!nvdla_core_rst) begin
      if (state_q == ST_HOLD) begin
        gnt_vld = 1'b1;
        gnt_id  = hold_id_q;
      end else begin
        gnt_vld = pick_vld;
        gnt_id  = pick_id;
      end
    end
    accept              = gnt_vld & dma_rd_req_rdy;
    dma_rd_req_vld      = gnt_vld;
    dma_rd_req_pd       = gnt_vld ? req_pd[gnt_id] : 79'd0;
    dma_rd_req_ram_type = gnt_vld & req_ram_type[gnt_id];
    req_rdy             = accept ? (4'b0001 << gnt_id) : 4'b0000;
    new_tag.id          = gnt_id;
    new_tag.ram_type    = req_ram_type[gnt_id];
    new_tag.size        = req_pd[gnt_id][78:64];
  end

  // Response steering from the oldest outstanding tag
  always_comb begin
    head                = tag_mem_q[rd_ptr_q];
    head_vld            = (tag_cnt_q != '0);
    dma_rd_rsp_rdy      = head_vld & rsp_rdy[head.id];
    dma_rd_rsp_ram_type = head_vld & head.ram_type;
    rsp_pd              = dma_rd_rsp_pd;
    for (int i = 0; i < 4; i++) begin
      rsp_vld[i] = dma_rd_rsp_vld & head_vld & (head.id == 2'(i));
    end
    rsp_beat = dma_rd_rsp_vld & dma_rd_rsp_rdy;
    tag_pop  = rsp_beat & (beat_cnt_q == head.size);
  end

  // Arbitration FSM: latch an unaccepted grant until the DMA takes it
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q   <= ST_IDLE;
      hold_id_q <= 2'd0;
      rr_ptr_q  <= 2'd0;
    end else begin
      if (accept) rr_ptr_q <= gnt_id + 2'd1;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld && !dma_rd_req_rdy) begin
            state_q   <= ST_HOLD;
            hold_id_q <= pick_id;
          end
        end
        ST_HOLD: begin
          if (dma_rd_req_rdy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outstanding beat credits: add on accept, subtract on pop, net in one step
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      out_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        out_q[i] <= out_q[i]
                  + ((accept && gnt_id == 2'(i)) ? beats[i][7:0] : 8'd0)
                  - {7'd0, pop_ok[i]};
      end
    end
  end

  // Tag storage; no reset needed because occupancy is tracked by tag_cnt_q
  always_ff @(posedge nvdla_core_clk) begin
    if (accept) tag_mem_q[wr_ptr_q] <= new_tag;
  end

  // Tag pointers, occupancy and in-burst beat counter
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_cnt_q  <= '0;
      beat_cnt_q <= 15'd0;
    end else begin
      if (accept)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tag_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      tag_cnt_q <= tag_cnt_q + TAG_CW'(accept) - TAG_CW'(tag_pop);
      if (rsp_beat) beat_cnt_q <= tag_pop ? 15'd0 : beat_cnt_q + 15'd1;
    end
  end

  // Sticky error: oversize request, credit underflow, or response with no tag
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (|(req_vld & too_big))
                     | (|(req_cdt_pop & ~pop_ok))
                     | (dma_rd_rsp_vld & ~head_vld);
    end
  end

  assign arb_err = err_q;

`ifdef SDP_RDMA_ARB_PERF_EN
  // Saturating per-requester grant and stall counters
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_rdy[i] && perf_grant_cnt[i] != 32'hFFFF_FFFF)
          perf_grant_cnt[i] <= perf_grant_cnt[i] + 32'd1;
        if (req_vld[i] && !req_rdy[i] && perf_stall_cnt[i] != 32'hFFFF_FFFF)
          perf_stall_cnt[i] <= perf_stall_cnt[i] + 32'd1;
      end
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_sdp_rdma_rd_arb.sv
// Directed bench for sdp_rdma_rd_arb with a queue-based reference model.
// Latency: model is evaluated every falling edge against the DUT's combinational outputs.
// Backpressure: requesters drop a request only after observing req_rdy.
module tb_sdp_rdma_rd_arb;
  localparam int LAT  = 64;
  localparam int TAGD = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_vld;
  logic [3:0]       req_rdy;
  logic [3:0][78:0] req_pd;
  logic [3:0]       req_ram_type;
  logic [3:0]       req_cdt_pop;
  logic             dma_rd_req_vld;
  logic             dma_rd_req_rdy;
  logic [78:0]      dma_rd_req_pd;
  logic             dma_rd_req_ram_type;
  logic             dma_rd_rsp_vld;
  logic             dma_rd_rsp_rdy;
  logic [256:0]     dma_rd_rsp_pd;
  logic             dma_rd_rsp_ram_type;
  logic [3:0]       rsp_vld;
  logic [3:0]       rsp_rdy;
  logic [256:0]     rsp_pd;
  logic             arb_err;
`ifdef SDP_RDMA_ARB_PERF_EN
  logic [3:0][31:0] perf_grant_cnt;
  logic [3:0][31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  sdp_rdma_rd_arb #(.LAT_DEPTH(LAT), .TAG_DEPTH(TAGD)) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rst      (rst),
    .req_vld             (req_vld),
    .req_rdy             (req_rdy),
    .req_pd              (req_pd),
    .req_ram_type        (req_ram_type),
    .req_cdt_pop         (req_cdt_pop),
    .dma_rd_req_vld      (dma_rd_req_vld),
    .dma_rd_req_rdy      (dma_rd_req_rdy),
    .dma_rd_req_pd       (dma_rd_req_pd),
    .dma_rd_req_ram_type (dma_rd_req_ram_type),
    .dma_rd_rsp_vld      (dma_rd_rsp_vld),
    .dma_rd_rsp_rdy      (dma_rd_rsp_rdy),
    .dma_rd_rsp_pd       (dma_rd_rsp_pd),
    .dma_rd_rsp_ram_type (dma_rd_rsp_ram_type),
    .rsp_vld             (rsp_vld),
    .rsp_rdy             (rsp_rdy),
    .rsp_pd              (rsp_pd),
    .arb_err             (arb_err)
`ifdef SDP_RDMA_ARB_PERF_EN
    ,
    .perf_grant_cnt      (perf_grant_cnt),
    .perf_stall_cnt      (perf_stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Stimulus-side requester queues: {ram_type, size, addr}
  logic [79:0] rq [4][$];
  int          grant_log[$];
  int          rsp_got[4];

  // Reference model state
  typedef struct {
    int   id;
    logic rt;
    int   beats;
  } mtag_t;

  int    m_rr;
  int    m_hold;
  int    m_out[4];
  int    m_cnt;
  logic  m_err;
  mtag_t m_tags[$];

  task automatic chk(input string nm, input logic [256:0] act, input logic [256:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0) begin
        req_vld[i]      = 1'b1;
        req_pd[i]       = rq[i][0][78:0];
        req_ram_type[i] = rq[i][0][79];
      end else begin
        req_vld[i]      = 1'b0;
        req_pd[i]       = '0;
        req_ram_type[i] = 1'b0;
      end
    end
  endtask

  task automatic push_req(input int id, input int size, input logic rt, input logic [63:0] addr);
    rq[id].push_back({rt, 15'(size), addr});
    drive_reqs();
  endtask

  task automatic set_rsp_pd();
    dma_rd_rsp_pd = {1'($urandom), $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
  endtask

  // Evaluate the model for the current cycle, compare, then advance it one edge.
  task automatic model_cycle();
    int    b[4];
    int    gid;
    int    id;
    logic  hv;
    logic  rsp_ok;
    mtag_t h;
    mtag_t t;
    logic [3:0] exp_rdy;
    logic [3:0] exp_rvld;

    for (int i = 0; i < 4; i++) b[i] = int'(req_pd[i][78:64]) + 1;
    gid = -1;
    if (m_hold >= 0) begin
      gid = m_hold;
    end else begin
      for (int k = 0; k < 4; k++) begin
        id = (m_rr + k) % 4;
        if (gid < 0 && req_vld[id] && (m_out[id] + b[id] <= LAT) && (m_tags.size() < TAGD))
          gid = id;
      end
    end

    chk("m_req_vld", 257'(dma_rd_req_vld), 257'(gid >= 0));
    if (gid >= 0) begin
      chk("m_req_pd", 257'(dma_rd_req_pd), 257'(req_pd[gid]));
      chk("m_req_rt", 257'(dma_rd_req_ram_type), 257'(req_ram_type[gid]));
    end
    exp_rdy = (gid >= 0 && dma_rd_req_rdy) ? 4'(1 << gid) : 4'd0;
    chk("m_req_rdy", 257'(req_rdy), 257'(exp_rdy));

    hv = (m_tags.size() > 0);
    h  = '{id: 0, rt: 1'b0, beats: 1};
    if (hv) h = m_tags[0];
    exp_rvld = (dma_rd_rsp_vld && hv) ? 4'(1 << h.id) : 4'd0;
    rsp_ok   = hv && rsp_rdy[h.id];
    chk("m_rsp_vld", 257'(rsp_vld), 257'(exp_rvld));
    chk("m_rsp_rdy", 257'(dma_rd_rsp_rdy), 257'(rsp_ok));
    chk("m_rsp_rt", 257'(dma_rd_rsp_ram_type), 257'(hv ? h.rt : 1'b0));
    chk("m_rsp_pd", rsp_pd, dma_rd_rsp_pd);
    chk("m_err", 257'(arb_err), 257'(m_err));

    // Advance to the next edge
    for (int i = 0; i < 4; i++) if (req_vld[i] && b[i] > LAT) m_err = 1'b1;
    if (dma_rd_rsp_vld && !hv) m_err = 1'b1;
    if (dma_rd_rsp_vld && rsp_ok) begin
      if (m_cnt == h.beats - 1) begin
        void'(m_tags.pop_front());
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (req_cdt_pop[i]) begin
        if (m_out[i] == 0) m_err = 1'b1;
        else m_out[i]--;
      end
    end
    if (gid >= 0) begin
      if (dma_rd_req_rdy) begin
        m_out[gid] += b[gid];
        t.id = gid; t.rt = req_ram_type[gid]; t.beats = b[gid];
        m_tags.push_back(t);
        m_rr   = (gid + 1) % 4;
        m_hold = -1;
      end else begin
        m_hold = gid;
      end
    end
  endtask

  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    model_cycle();
    acc = req_vld & req_rdy;
    for (int i = 0; i < 4; i++) begin
      rsp_got[i] += int'(rsp_vld[i] & rsp_rdy[i]);
      if (acc[i]) begin
        grant_log.push_back(i);
        void'(rq[i].pop_front());
      end
    end
    @(posedge clk);
    #1;
    req_cdt_pop = '0;
    drive_reqs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rq[i].delete();
      rsp_got[i] = 0;
      m_out[i]   = 0;
    end
    drive_reqs();
    req_cdt_pop    = '0;
    dma_rd_req_rdy = 1'b0;
    dma_rd_rsp_vld = 1'b0;
    dma_rd_rsp_pd  = '0;
    rsp_rdy        = '0;
    grant_log.delete();
    m_rr = 0; m_hold = -1; m_cnt = 0; m_err = 1'b0;
    m_tags.delete();
    #3;
    chk("rst_req_vld", 257'(dma_rd_req_vld), 257'(0));
    chk("rst_req_rdy", 257'(req_rdy), 257'(0));
    chk("rst_rsp_vld", 257'(rsp_vld), 257'(0));
    chk("rst_rsp_rdy", 257'(dma_rd_rsp_rdy), 257'(0));
    chk("rst_req_rt", 257'(dma_rd_req_ram_type), 257'(0));
    chk("rst_rsp_rt", 257'(dma_rd_rsp_ram_type), 257'(0));
    chk("rst_err", 257'(arb_err), 257'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int exp_t1[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Round-robin order over four single-beat requesters
    do_reset();
    push_req(0, 0, 1'b1, 64'h1000);
    push_req(0, 0, 1'b0, 64'h1040);
    push_req(1, 0, 1'b0, 64'h2000);
    push_req(2, 0, 1'b1, 64'h3000);
    push_req(3, 0, 1'b0, 64'h4000);
    dma_rd_req_rdy = 1'b1;
    repeat (5) step();
    chk("t1_ngrant", 257'(grant_log.size()), 257'(5));
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) chk("t1_order", 257'(grant_log[k]), 257'(exp_t1[k]));
    step();

    // Credit exhaustion and release
    do_reset();
    push_req(0, 31, 1'b0, 64'h100);
    push_req(0, 31, 1'b0, 64'h200);
    push_req(0, 0, 1'b0, 64'h300);
    dma_rd_req_rdy = 1'b1;
    repeat (4) step();
    chk("t2_blocked", 257'(grant_log.size()), 257'(2));
    req_cdt_pop[0] = 1'b1;
    step();
    chk("t2_pop_cycle", 257'(grant_log.size()), 257'(2));
    step();
    chk("t2_unblocked", 257'(grant_log.size()), 257'(3));

    // Held grant ignores a newly valid requester
    do_reset();
    push_req(2, 5, 1'b1, 64'hAAAA);
    step();
    push_req(1, 0, 1'b0, 64'hBBBB);
    repeat (4) begin
      step();
      #1;
      chk("t3_hold_pd", 257'(dma_rd_req_pd), 257'({15'd5, 64'hAAAA}));
      chk("t3_hold_rt", 257'(dma_rd_req_ram_type), 257'(1));
    end
    dma_rd_req_rdy = 1'b1;
    step();
    step();
    chk("t3_ngrant", 257'(grant_log.size()), 257'(2));
    if (grant_log.size() == 2) begin
      chk("t3_first", 257'(grant_log[0]), 257'(2));
      chk("t3_wrap", 257'(grant_log[1]), 257'(1));
    end

    // Response steering and backpressure
    do_reset();
    dma_rd_req_rdy = 1'b1;
    push_req(1, 2, 1'b0, 64'h5000);
    push_req(3, 0, 1'b1, 64'h6000);
    step();
    step();
    dma_rd_req_rdy = 1'b0;
    chk("t4_ngrant", 257'(grant_log.size()), 257'(2));
    dma_rd_rsp_vld = 1'b1;
    rsp_rdy = 4'b1101;
    set_rsp_pd();
    #1;
    chk("t4_stall_rdy", 257'(dma_rd_rsp_rdy), 257'(0));
    chk("t4_stall_vld", 257'(rsp_vld), 257'(4'b0010));
    step();
    step();
    chk("t4_stall_cnt", 257'(rsp_got[1]), 257'(0));
    rsp_rdy = 4'b1111;
    repeat (3) begin
      set_rsp_pd();
      step();
    end
    #1;
    chk("t4_id3_vld", 257'(rsp_vld), 257'(4'b1000));
    chk("t4_id3_rt", 257'(dma_rd_rsp_ram_type), 257'(1));
    step();
    dma_rd_rsp_vld = 1'b0;
    chk("t4_beats1", 257'(rsp_got[1]), 257'(3));
    chk("t4_beats3", 257'(rsp_got[3]), 257'(1));
    step();
    chk("t4_no_err", 257'(arb_err), 257'(0));

    // Tag FIFO full, then one completion frees a slot
    do_reset();
    dma_rd_req_rdy = 1'b1;
    for (int k = 0; k < 9; k++) push_req(0, 0, 1'b0, 64'(k * 64));
    repeat (10) step();
    chk("t5_full", 257'(grant_log.size()), 257'(8));
    dma_rd_rsp_vld = 1'b1;
    rsp_rdy = 4'b1111;
    set_rsp_pd();
    step();
    dma_rd_rsp_vld = 1'b0;
    chk("t5_pop_cycle", 257'(grant_log.size()), 257'(8));
    step();
    chk("t5_unblocked", 257'(grant_log.size()), 257'(9));

    // Sticky error sources
    do_reset();
    dma_rd_rsp_vld = 1'b1;
    #1;
    chk("t6_empty_rdy", 257'(dma_rd_rsp_rdy), 257'(0));
    step();
    dma_rd_rsp_vld = 1'b0;
    #1;
    chk("t6_empty_err", 257'(arb_err), 257'(1));
    repeat (3) step();
    chk("t6_sticky", 257'(arb_err), 257'(1));

    do_reset();
    dma_rd_req_rdy = 1'b1;
    push_req(2, 100, 1'b0, 64'h7000);
    repeat (3) step();
    chk("t6_big_err", 257'(arb_err), 257'(1));
    chk("t6_big_nogrant", 257'(grant_log.size()), 257'(0));

    do_reset();
    req_cdt_pop[1] = 1'b1;
    step();
    #1;
    chk("t6_underflow_err", 257'(arb_err), 257'(1));

    do_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
